// File: rtl/resonant_sweep_ctrl.sv
// Sweep controller for resonant_sys: steps the reference word across a range,
// counts charge pulses for each step and reports every step over a valid/ready handshake.
module resonant_sweep_ctrl #(
    parameter int BUS_WIDTH      = 10,
    parameter int CNT_WIDTH      = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [BUS_WIDTH-1:0] cfg_ref_first,
    input  logic [BUS_WIDTH-1:0] cfg_ref_step,
    input  logic [7:0]           cfg_n_steps,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 start,
    input  logic                 q_serialized,
    input  logic                 pulses_ended,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BUS_WIDTH-1:0] res_ref,
    output logic [CNT_WIDTH-1:0] res_count,
    output logic                 res_timeout,
    output logic                 busy,
    output logic                 done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_REPORT, S_NEXT, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] cur_ref_q, cur_ref_d;
    logic [BUS_WIDTH-1:0] step_q, step_d;
    logic [7:0]           steps_q, steps_d;
    logic [BUS_WIDTH-1:0] i_ref_q, i_ref_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [TW-1:0]        run_q, run_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 q_prev_q, q_prev_d;
    logic [BUS_WIDTH-1:0] res_ref_q, res_ref_d;
    logic                 res_timeout_q, res_timeout_d;
    logic [BUS_WIDTH:0]   ref_sum;
    logic                 pulse_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_ref_q     <= '0;
            step_q        <= '0;
            steps_q       <= '0;
            i_ref_q       <= '0;
            settle_q      <= '0;
            run_q         <= '0;
            cnt_q         <= '0;
            q_prev_q      <= 1'b0;
            res_ref_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_ref_q     <= cur_ref_d;
            step_q        <= step_d;
            steps_q       <= steps_d;
            i_ref_q       <= i_ref_d;
            settle_q      <= settle_d;
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            q_prev_q      <= q_prev_d;
            res_ref_q     <= res_ref_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_ref_d     = cur_ref_q;
        step_d        = step_q;
        steps_d       = steps_q;
        i_ref_d       = i_ref_q;
        settle_d      = settle_q;
        run_d         = run_q;
        cnt_d         = cnt_q;
        q_prev_d      = q_serialized;
        res_ref_d     = res_ref_q;
        res_timeout_d = res_timeout_q;
        pulse_edge    = q_serialized & ~q_prev_q;
        ref_sum       = {1'b0, cur_ref_q} + {1'b0, step_q};

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    cur_ref_d = cfg_ref_first;
                    step_d    = cfg_ref_step;
                    steps_d   = cfg_n_steps;
                    state_d   = (cfg_n_steps == 8'd0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                i_ref_d       = cur_ref_q;
                cnt_d         = '0;
                settle_d      = '0;
                run_d         = '0;
                q_prev_d      = 1'b0;
                res_timeout_d = 1'b0;
                state_d       = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // An edge arriving together with pulses_ended still belongs to this step.
                if (pulse_edge && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                run_d = run_q + TW'(1);
                if (pulses_ended) begin
                    res_ref_d     = i_ref_q;
                    res_timeout_d = 1'b0;
                    state_d       = S_REPORT;
                end else if (run_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_ref_d     = i_ref_q;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                steps_d   = steps_q - 8'd1;
                cur_ref_d = ref_sum[BUS_WIDTH] ? {BUS_WIDTH{1'b1}} : ref_sum[BUS_WIDTH-1:0];
                state_d   = (steps_q == 8'd1) ? S_FIN : S_LOAD;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign i_ref       = i_ref_q;
    assign start       = (state_q == S_RUN);
    assign res_valid   = (state_q == S_REPORT);
    assign res_ref     = res_ref_q;
    assign res_count   = cnt_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);

endmodule

// File: tb/tb_resonant_sweep_ctrl.sv
// Randomized bench for resonant_sweep_ctrl: emulates resonant_sys and compares every
// reported step against a sweep model built from saturating arithmetic and edge counting.
module tb_resonant_sweep_ctrl;

    localparam int BW      = 10;
    localparam int CW      = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [BW-1:0] cfg_ref_first;
    logic [BW-1:0] cfg_ref_step;
    logic [7:0]    cfg_n_steps;
    logic [BW-1:0] i_ref;
    logic          start;
    logic          q_serialized;
    logic          pulses_ended;
    logic          res_valid;
    logic          res_ready;
    logic [BW-1:0] res_ref;
    logic [CW-1:0] res_count;
    logic          res_timeout;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    resonant_sweep_ctrl #(
        .BUS_WIDTH(BW), .CNT_WIDTH(CW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ref_first(cfg_ref_first),
        .cfg_ref_step(cfg_ref_step), .cfg_n_steps(cfg_n_steps), .i_ref(i_ref), .start(start),
        .q_serialized(q_serialized), .pulses_ended(pulses_ended), .res_valid(res_valid),
        .res_ready(res_ready), .res_ref(res_ref), .res_count(res_count),
        .res_timeout(res_timeout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference of step k: repeated addition, clipped at the top of the bus range.
    function automatic int modelRef(input int first, input int step, input int k);
        int r = first;
        for (int i = 0; i < k; i++) begin
            r = r + step;
            if (r > (1 << BW) - 1) r = (1 << BW) - 1;
        end
        return r;
    endfunction

    // mode 0: pulses_ended at random cycle, 1: never (timeout), 2: at the timeout cycle,
    // 3: 60 clean edges with the last one coinciding with pulses_ended.
    task automatic applyStimulus(input int first, input int step, input int n,
                                 input int rdyDelay, input int mode, input int resetAt);
        int  preCycles, runCycles, endAt, expCount, expTimeout, expRef;
        bit  noise, endsByPe;
        logic prevQ;
        noise    = (mode != 3);
        endsByPe = (mode != 1);
        cfg_ref_first = BW'(first);
        cfg_ref_step  = BW'(step);
        cfg_n_steps   = 8'(n);
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start     = 1'b0;
        cfg_ref_first = BW'($urandom);
        cfg_ref_step  = BW'($urandom);
        cfg_n_steps   = 8'($urandom);
        if (n == 0) begin
            checkOutput("n0_done", done, 1);
            checkOutput("n0_valid", res_valid, 0);
            @(negedge clk);
            checkOutput("n0_idle_busy", busy, 0);
            checkOutput("n0_idle_done", done, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            expRef    = modelRef(first, step, k);
            preCycles = 0;
            prevQ     = 1'b0;
            while (!start && preCycles < 200) begin
                preCycles++;
                q_serialized = noise ? 1'($urandom) : 1'b0;
                pulses_ended = 1'b0;
                prevQ        = q_serialized;
                @(negedge clk);
            end
            checkOutput("settle_len", preCycles, (k == 0) ? SETTLE + 1 : SETTLE + 2);
            checkOutput("run_iref", i_ref, expRef);
            case (mode)
                0:       endAt = $urandom_range(2, 150);
                3:       endAt = 119;
                default: endAt = TIMEOUT;
            endcase
            expTimeout = (mode == 1) ? 1 : 0;
            runCycles  = 0;
            expCount   = 0;
            while (start && runCycles < TIMEOUT + 50) begin
                runCycles++;
                if (resetAt > 0 && runCycles == resetAt) begin
                    rst = 1'b1;
                    q_serialized = 1'b0;
                    pulses_ended = 1'b0;
                    @(negedge clk);
                    checkOutput("rst_start", start, 0);
                    checkOutput("rst_busy", busy, 0);
                    checkOutput("rst_iref", i_ref, 0);
                    checkOutput("rst_valid", res_valid, 0);
                    checkOutput("rst_count", res_count, 0);
                    rst = 1'b0;
                    @(negedge clk);
                    checkOutput("rst_stay_idle", busy, 0);
                    return;
                end
                q_serialized  = (mode == 3) ? 1'(runCycles % 2) : 1'($urandom);
                pulses_ended  = endsByPe && (runCycles == endAt);
                cfg_start     = ($urandom_range(0, 7) == 0);
                cfg_ref_first = BW'($urandom);
                if (q_serialized && !prevQ && expCount < (1 << CW) - 1) expCount++;
                prevQ = q_serialized;
                @(negedge clk);
            end
            cfg_start    = 1'b0;
            q_serialized = 1'b0;
            pulses_ended = 1'b0;
            checkOutput("run_len", runCycles, endAt);
            for (int d = 0; d <= rdyDelay; d++) begin
                checkOutput("rep_valid", res_valid, 1);
                checkOutput("rep_ref", res_ref, expRef);
                checkOutput("rep_count", res_count, expCount);
                checkOutput("rep_timeout", res_timeout, expTimeout);
                checkOutput("rep_start", start, 0);
                checkOutput("rep_iref", i_ref, expRef);
                res_ready    = (d == rdyDelay);
                q_serialized = 1'($urandom);
                @(negedge clk);
            end
            res_ready    = 1'b0;
            q_serialized = 1'b0;
            checkOutput("ack_valid", res_valid, 0);
        end
        checkOutput("next_done", done, 0);
        @(negedge clk);
        checkOutput("fin_done", done, 1);
        cfg_start   = 1'b1;
        cfg_n_steps = 8'd3;
        @(negedge clk);
        cfg_start = 1'b0;
        checkOutput("post_done", done, 0);
        checkOutput("post_busy", busy, 0);
        @(negedge clk);
        checkOutput("fin_start_ignored", busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_ref_first = '0;
        cfg_ref_step  = '0;
        cfg_n_steps   = '0;
        q_serialized  = 1'b0;
        pulses_ended  = 1'b0;
        res_ready     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_valid", res_valid, 0);
        checkOutput("reset_iref", i_ref, 0);
        checkOutput("reset_count", res_count, 0);
        checkOutput("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(600, 0, 1, 0, 3, 0);
        applyStimulus(600, 200, 3, 2, 0, 0);
        applyStimulus(1000, 100, 2, 1, 0, 0);
        applyStimulus(300, 7, 1, 20, 0, 0);
        applyStimulus(50, 1, 1, 0, 1, 0);
        applyStimulus(60, 1, 1, 0, 2, 0);
        applyStimulus(100, 5, 2, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 1023), $urandom_range(0, 400),
                          $urandom_range(1, 4), $urandom_range(0, 3), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
